// File: rtl/t_flip_flop_pkg.sv
// Shared definitions for the toggle flip-flop: reset level and the next-state rule
// used by every bit cell.
package t_flip_flop_pkg;

    localparam logic TFF_RST_LVL = 1'b1;

    // Reset outranks toggle: a toggle requested on a reset edge is dropped, not deferred.
    function automatic logic tff_next(
        input logic q,
        input logic t,
        input logic rst,
        input logic rst_val = 1'b0
    );
        if (rst == TFF_RST_LVL) begin
            return rst_val;
        end
        return q ^ t;
    endfunction

endpackage

// File: rtl/t_flip_flop_cell.sv
// Single-bit toggle flop with synchronous active-high reset; the building block
// replicated by t_flip_flop.
module t_flip_flop_cell
    import t_flip_flop_pkg::*;
#(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic t,
    input  logic rst,
    input  logic clk,
    output logic q
);

    // NOTE: non-blocking assignment so every cell samples the pre-edge q;
    // a blocking update would let downstream logic see the new value on the same edge.
    always_ff @(posedge clk) begin
        q <= tff_next(q, t, rst, RESET_VALUE);
    end

endmodule

// File: rtl/t_flip_flop.sv
// WIDTH independent toggle bits with a combinational complement output.
// Port order (t, rst, clk, q, qb) is relied on by positional instantiations.
module t_flip_flop
    import t_flip_flop_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic [WIDTH-1:0] t,
    input  logic             rst,
    input  logic             clk,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb
);

    if (WIDTH < 1) begin : g_width_check
        $error("t_flip_flop: WIDTH must be at least 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        t_flip_flop_cell #(
            .RESET_VALUE(RESET_VALUE[i])
        ) u_cell (
            .t  (t[i]),
            .rst(rst),
            .clk(clk),
            .q  (q[i])
        );
    end

    // Complement taken straight from the register so q and qb can never disagree.
    assign qb = ~q;

endmodule

// File: tb/tb_t_flip_flop.sv
// Self-checking bench: a 1-bit and a 4-bit toggle flip-flop driven by directed
// steps and random traffic, compared against a toggle-count parity model.
module tb_t_flip_flop;

    localparam logic [3:0] RV4 = 4'b1010;

    logic       clk;
    logic       rst;
    logic       t1;
    logic [3:0] t4;
    logic       q1, qb1;
    logic [3:0] q4, qb4;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Model: number of toggles each bit has seen since its last reset.
    int tog1;
    int tog4 [4];

    t_flip_flop u_dut1 (
        .t  (t1),
        .rst(rst),
        .clk(clk),
        .q  (q1),
        .qb (qb1)
    );

    t_flip_flop #(
        .WIDTH      (4),
        .RESET_VALUE(RV4)
    ) u_dut4 (
        .t  (t4),
        .rst(rst),
        .clk(clk),
        .q  (q4),
        .qb (qb4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic exp_q1();
        return logic'(tog1 % 2);
    endfunction

    function automatic logic [3:0] exp_q4();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = RV4[i] ^ logic'(tog4[i] % 2);
        return v;
    endfunction

    // Drive on negedge, let one posedge happen, update the model, then compare.
    task automatic step(input logic r, input logic a1, input logic [3:0] a4);
        @(negedge clk);
        rst = r;
        t1  = a1;
        t4  = a4;
        @(posedge clk);
        if (r) begin
            tog1 = 0;
            for (int i = 0; i < 4; i++) tog4[i] = 0;
        end else begin
            tog1 += int'(a1);
            for (int i = 0; i < 4; i++) tog4[i] += int'(a4[i]);
        end
        #1;
        check("q1_model",  {3'b0, q1},  {3'b0, exp_q1()});
        check("qb1_model", {3'b0, qb1}, {3'b0, ~exp_q1()});
        check("q4_model",  q4,  exp_q4());
        check("qb4_model", qb4, ~exp_q4());
    endtask

    initial begin
        rst  = 1'b1;
        t1   = 1'b0;
        t4   = 4'b0000;
        tog1 = 0;
        for (int i = 0; i < 4; i++) tog4[i] = 0;

        // Reset with t=0
        step(1'b1, 1'b0, 4'b0000);
        check("rst_q1",  {3'b0, q1},  4'b0000);
        check("rst_qb1", {3'b0, qb1}, 4'b0001);
        check("rst_q4",  q4,  4'b1010);
        check("rst_qb4", qb4, 4'b0101);
        check("rst_no_x", {3'b0, $isunknown({q1, q4})}, 4'b0000);

        // Idle after reset
        step(1'b0, 1'b0, 4'b0000);
        check("idle0_q1", {3'b0, q1}, 4'b0000);
        step(1'b0, 1'b0, 4'b0000);
        check("idle1_q1", {3'b0, q1}, 4'b0000);
        check("idle1_q4", q4, 4'b1010);

        // Directed toggle sequence, with the wide flop doing its own pattern
        step(1'b0, 1'b0, 4'b0000);
        check("seq_t0_q1", {3'b0, q1}, 4'b0000);
        step(1'b0, 1'b1, 4'b0110);
        check("seq_t1_q1",  {3'b0, q1},  4'b0001);
        check("seq_t1_qb1", {3'b0, qb1}, 4'b0000);
        check("w4_t0110", q4, 4'b1100);
        step(1'b0, 1'b1, 4'b1111);
        check("seq_t1b_q1",  {3'b0, q1},  4'b0000);
        check("seq_t1b_qb1", {3'b0, qb1}, 4'b0001);
        check("w4_t1111",  q4,  4'b0011);
        check("w4_qb1111", qb4, 4'b1100);
        step(1'b0, 1'b0, 4'b0000);
        check("seq_hold_q1", {3'b0, q1}, 4'b0000);
        check("w4_hold",     q4, 4'b0011);

        // t held high: divide-by-two pattern 1,0,1,0,...
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 4'b0000);
            check("div2_q1", {3'b0, q1}, (i % 2 == 0) ? 4'b0001 : 4'b0000);
            check("div2_ne", {3'b0, q1 ^ qb1}, 4'b0001);
        end

        // Reset wins over a simultaneous toggle
        step(1'b0, 1'b1, 4'b1111);
        check("prio_pre_q1", {3'b0, q1}, 4'b0001);
        step(1'b1, 1'b1, 4'b1111);
        check("prio_rst_q1", {3'b0, q1}, 4'b0000);
        check("prio_rst_q4", q4, 4'b1010);
        step(1'b1, 1'b1, 4'b0101);
        check("prio_held_q1", {3'b0, q1}, 4'b0000);
        check("prio_held_q4", q4, 4'b1010);
        step(1'b0, 1'b1, 4'b0001);
        check("prio_post_q1", {3'b0, q1}, 4'b0001);
        check("prio_post_q4", q4, 4'b1011);

        // Random traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(15) == 0), 1'($urandom), 4'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
